// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: merges in-order WB writes with a FIFO of
// long-latency-unit (LU) writes; WB wins and kills older queued writes.
//
// Ports:
//   clk_i, rst_i                       clock, async active-low reset
//   wb_we_i, wb_addr_i, wb_data_i      writeback write request (never stalled)
//   lu_valid_i, lu_ready_o,
//   lu_addr_i, lu_data_i               LU write request with valid/ready
//   rs_addr_i, rt_addr_i               decode-stage source registers
//   rs_pending_o, rt_pending_o         source has a live queued LU write
//   RegWrite_o, RDaddr_o, RDdata_o     registered register-file write port
//   count_o                            LU FIFO occupancy (killed entries too)
module regfile_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wb_we_i,
    input  logic [AW-1:0]          wb_addr_i,
    input  logic [DW-1:0]          wb_data_i,
    input  logic                   lu_valid_i,
    output logic                   lu_ready_o,
    input  logic [AW-1:0]          lu_addr_i,
    input  logic [DW-1:0]          lu_data_i,
    input  logic [AW-1:0]          rs_addr_i,
    input  logic [AW-1:0]          rt_addr_i,
    output logic                   rs_pending_o,
    output logic                   rt_pending_o,
    output logic                   RegWrite_o,
    output logic [AW-1:0]          RDaddr_o,
    output logic [DW-1:0]          RDdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    fifo_addr [DEPTH];
    logic [DW-1:0]    fifo_data [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [DEPTH-1:0] live_d;
    logic [DEPTH-1:0] kill;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic             we_q;
    logic [AW-1:0]    rd_addr_q;
    logic [DW-1:0]    rd_data_q;
    logic             we_d;
    logic [AW-1:0]    rd_addr_d;
    logic [DW-1:0]    rd_data_d;

    logic wb_act;
    logic accept;
    logic empty;
    logic head_live;
    logic pop;
    logic lu_live;
    logic rs_hit;
    logic rt_hit;

    // Ready depends only on registered occupancy, so a full FIFO refuses an
    // accept even in a cycle where it also pops.
    assign lu_ready_o = (count_q < CW'(DEPTH));
    assign accept     = lu_valid_i & lu_ready_o;
    assign empty      = (count_q == '0);

    // Writes to r0 are dropped outright and never kill anything.
    assign wb_act     = wb_we_i & (wb_addr_i != '0);
    assign head_live  = live_q[head_q];

    // A live head only leaves when WB is idle; a dead head leaves at once.
    assign pop        = ~empty & (~wb_act | ~head_live);

    // WB is program-order newer than a same-cycle LU accept, so it kills it.
    assign lu_live    = (lu_addr_i != '0) &
                        ~(wb_act & (lu_addr_i == wb_addr_i));

    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = wb_act & (fifo_addr[i] == wb_addr_i);
        end
    end

    // Live bits are cleared on pop, so live implies the slot is occupied.
    always_comb begin
        live_d = live_q & ~kill;
        if (pop) begin
            live_d[head_q] = 1'b0;
        end
        if (accept) begin
            live_d[tail_q] = lu_live;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        we_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (wb_act) begin
            we_d      = 1'b1;
            rd_addr_d = wb_addr_i;
            rd_data_d = wb_data_i;
        end else if (~empty & head_live) begin
            we_d      = 1'b1;
            rd_addr_d = fifo_addr[head_q];
            rd_data_d = fifo_data[head_q];
        end
    end

    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (fifo_addr[i] == rs_addr_i)) begin
                rs_hit = 1'b1;
            end
            if (live_q[i] && (fifo_addr[i] == rt_addr_i)) begin
                rt_hit = 1'b1;
            end
        end
    end

    assign rs_pending_o = rs_hit & (rs_addr_i != '0);
    assign rt_pending_o = rt_hit & (rt_addr_i != '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else if (accept) begin
            fifo_addr[tail_q] <= lu_addr_i;
            fifo_data[tail_q] <= lu_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            live_q  <= live_d;
            count_q <= count_d;
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            if (accept) begin
                tail_q <= tail_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign RegWrite_o = we_q;
    assign RDaddr_o   = rd_addr_q;
    assign RDdata_o   = rd_data_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          wb_we_i;
    logic [AW-1:0] wb_addr_i;
    logic [DW-1:0] wb_data_i;
    logic          lu_valid_i;
    logic          lu_ready_o;
    logic [AW-1:0] lu_addr_i;
    logic [DW-1:0] lu_data_i;
    logic [AW-1:0] rs_addr_i;
    logic [AW-1:0] rt_addr_i;
    logic          rs_pending_o;
    logic          rt_pending_o;
    logic          RegWrite_o;
    logic [AW-1:0] RDaddr_o;
    logic [DW-1:0] RDdata_o;
    logic [2:0]    count_o;

    regfile_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wb_we_i      (wb_we_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .lu_valid_i   (lu_valid_i),
        .lu_ready_o   (lu_ready_o),
        .lu_addr_i    (lu_addr_i),
        .lu_data_i    (lu_data_i),
        .rs_addr_i    (rs_addr_i),
        .rt_addr_i    (rt_addr_i),
        .rs_pending_o (rs_pending_o),
        .rt_pending_o (rt_pending_o),
        .RegWrite_o   (RegWrite_o),
        .RDaddr_o     (RDaddr_o),
        .RDdata_o     (RDdata_o),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            live;
    } ent_t;

    ent_t          q[$];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] rf_dut [32];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_pend(input logic [AW-1:0] a);
        bit hit = 0;
        foreach (q[i]) if (q[i].live && q[i].a == a) hit = 1;
        return hit && (a != 0);
    endfunction

    // Reference: WB wins; otherwise the oldest queued write retires if not
    // killed. WB then kills all older writes to its register.
    task automatic model_step();
        bit   wbact;
        bit   acc;
        ent_t e;
        wbact = wb_we_i && (wb_addr_i != 0);
        acc   = lu_valid_i && (q.size() < DEPTH);
        m_we  = 0;
        if (wbact) begin
            m_we   = 1;
            m_addr = wb_addr_i;
            m_data = wb_data_i;
            if (q.size() > 0 && !q[0].live) e = q.pop_front();
        end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e.live) begin
                m_we   = 1;
                m_addr = e.a;
                m_data = e.d;
            end
        end
        if (wbact) begin
            foreach (q[i]) if (q[i].a == wb_addr_i) q[i].live = 0;
        end
        if (acc) begin
            e.a    = lu_addr_i;
            e.d    = lu_data_i;
            e.live = (lu_addr_i != 0) &&
                     !(wbact && lu_addr_i == wb_addr_i);
            q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clk_i);
        check("lu_ready", 32'(lu_ready_o), 32'(q.size() < DEPTH));
        check("rs_pend", 32'(rs_pending_o), 32'(m_pend(rs_addr_i)));
        check("rt_pend", 32'(rt_pending_o), 32'(m_pend(rt_addr_i)));
        model_step();
        @(posedge clk_i);
        #1;
        check("regwrite", 32'(RegWrite_o), 32'(m_we));
        check("rdaddr", 32'(RDaddr_o), 32'(m_addr));
        check("rddata", RDdata_o, m_data);
        check("count", 32'(count_o), 32'(q.size()));
        if (RegWrite_o === 1'b1) rf_dut[RDaddr_o] = RDdata_o;
    endtask

    task automatic idle();
        wb_we_i    = 0;
        wb_addr_i  = 0;
        wb_data_i  = 0;
        lu_valid_i = 0;
        lu_addr_i  = 0;
        lu_data_i  = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, 32'(RegWrite_o), 0);
        check({tag, "_addr"}, 32'(RDaddr_o), 0);
        check({tag, "_data"}, RDdata_o, 0);
        check({tag, "_count"}, 32'(count_o), 0);
        check({tag, "_ready"}, 32'(lu_ready_o), 1);
        check({tag, "_rs"}, 32'(rs_pending_o), 0);
        check({tag, "_rt"}, 32'(rt_pending_o), 0);
    endtask

    initial begin
        foreach (rf_dut[i]) rf_dut[i] = 0;
        idle();
        rs_addr_i = 0;
        rt_addr_i = 0;
        rst_i     = 0;
        m_we      = 0;
        m_addr    = 0;
        m_data    = 0;
        #12;
        check_reset_vals("rst0");
        @(negedge clk_i);
        rst_i = 1;
        @(posedge clk_i);
        #1;

        // single LU write
        lu_valid_i = 1; lu_addr_i = 7; lu_data_i = 32'h1234;
        cycle();
        idle();
        cycle();
        check("t1_we", 32'(RegWrite_o), 1);
        check("t1_addr", 32'(RDaddr_o), 7);
        check("t1_data", RDdata_o, 32'h1234);
        check("t1_count", 32'(count_o), 0);

        // WB priority over a queued LU write
        for (int k = 0; k < 3; k++) begin
            wb_we_i = 1; wb_addr_i = AW'(3 + k); wb_data_i = 32'(100 + k);
            lu_valid_i = (k == 0); lu_addr_i = 9; lu_data_i = 32'h99;
            cycle();
        end
        idle();
        for (int k = 0; k < 2; k++) cycle();

        // full FIFO with WB holding the port
        rs_addr_i = 12;
        for (int k = 0; k < 5; k++) begin
            wb_we_i = 1; wb_addr_i = 1; wb_data_i = 32'(k);
            lu_valid_i = 1; lu_addr_i = AW'(10 + k);
            lu_data_i = 32'(32'hF00 + k);
            cycle();
        end
        check("full_count", 32'(count_o), 4);
        check("full_ready", 32'(lu_ready_o), 0);
        check("full_rs12", 32'(rs_pending_o), 1);
        idle();
        for (int k = 0; k < 5; k++) cycle();

        // kill of a queued write by a newer WB write
        rs_addr_i = 8;
        wb_we_i = 1; wb_addr_i = 2; wb_data_i = 32'h22;
        lu_valid_i = 1; lu_addr_i = 8; lu_data_i = 32'hAAAA;
        cycle();
        lu_valid_i = 0;
        wb_addr_i = 8; wb_data_i = 32'h5555;
        cycle();
        idle();
        check("kill_pend", 32'(rs_pending_o), 0);
        for (int k = 0; k < 3; k++) cycle();
        check("kill_r8", rf_dut[8], 32'h5555);

        // register 0 from both sources
        rs_addr_i = 0; rt_addr_i = 0;
        wb_we_i = 1; wb_addr_i = 0; wb_data_i = 32'hDEAD;
        lu_valid_i = 1; lu_addr_i = 0; lu_data_i = 32'hBEEF;
        cycle();
        check("r0_we", 32'(RegWrite_o), 0);
        idle();
        cycle();
        check("r0_we2", 32'(RegWrite_o), 0);
        check("r0_count", 32'(count_o), 0);

        // asynchronous reset with queued writes
        rs_addr_i = 20;
        for (int k = 0; k < 3; k++) begin
            wb_we_i = 1; wb_addr_i = 1; wb_data_i = 32'(k);
            lu_valid_i = 1; lu_addr_i = AW'(20 + k); lu_data_i = 32'(k);
            cycle();
        end
        idle();
        #2;
        rst_i = 0;
        #1;
        check_reset_vals("rst1");
        q.delete();
        m_we = 0; m_addr = 0; m_data = 0;
        @(negedge clk_i);
        rst_i = 1;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 4; k++) cycle();

        // random traffic on a small register range to provoke kills
        for (int k = 0; k < 1500; k++) begin
            wb_we_i    = ($urandom_range(0, 99) < 55);
            wb_addr_i  = AW'($urandom_range(0, 7));
            wb_data_i  = $urandom;
            lu_valid_i = ($urandom_range(0, 99) < 50);
            lu_addr_i  = AW'($urandom_range(0, 7));
            lu_data_i  = $urandom;
            rs_addr_i  = AW'($urandom_range(0, 7));
            rt_addr_i  = AW'($urandom_range(0, 7));
            cycle();
        end
        idle();
        for (int k = 0; k < 6; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Sole driver of the register file write port (RDaddr/RDdata/RegWrite).
- Merges two write sources into one registered write per cycle:
  - WB: the in-order pipeline writeback. Highest priority, never stalled.
  - LU: a long-latency unit (mul/div) with a valid/ready handshake. Its writes are buffered in a DEPTH-entry FIFO.
- Exposes pending-write flags so the hazard unit can stall readers of registers with queued LU writes.

Parameters:
- DEPTH, 4, LU FIFO entries; power of two, at least 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- wb_we_i  in  1  WB write request.
- wb_addr_i  in  AW  WB destination register.
- wb_data_i  in  DW  WB write data.
- lu_valid_i  in  1  LU write request valid.
- lu_ready_o  out  1  FIFO can accept an LU write.
- lu_addr_i  in  AW  LU destination register.
- lu_data_i  in  DW  LU write data.
- rs_addr_i  in  AW  decode-stage source register 1.
- rt_addr_i  in  AW  decode-stage source register 2.
- rs_pending_o  out  1  rs_addr_i has a live queued LU write.
- rt_pending_o  out  1  rt_addr_i has a live queued LU write.
- RegWrite_o  out  1  register file write enable.
- RDaddr_o  out  AW  register file write address.
- RDdata_o  out  DW  register file write data.
- count_o  out  clog2(DEPTH)+1  FIFO occupancy, including killed entries.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FIFO emptied; all entry live bits cleared; pointers cleared.
  - RegWrite_o=0, RDaddr_o=0, RDdata_o=0, count_o=0, lu_ready_o=1, pending outputs 0.
  - Reset mid-operation discards all queued writes and suppresses any write in flight.
- FIFO entries: {addr, data, live}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Full when count_o==DEPTH; empty when count_o==0.
- lu_ready_o = (count_o < DEPTH), decoded from registered state only; it has no combinational path from any input.
- LU accept = lu_valid_i & lu_ready_o.
  - An accepted entry is written at the tail with live=1.
  - live=0 if lu_addr_i==0.
  - live=0 if it is killed by a WB write in the same cycle (see kill rule).
- An accept and a pop in the same cycle are both performed; count is unchanged.
- A full FIFO with a pop in the same cycle still refuses the accept, because ready comes from registered count.
- Per-cycle arbitration, evaluated on the rising edge:
  1. If wb_we_i=1 and wb_addr_i!=0: next RegWrite_o=1, RDaddr_o=wb_addr_i, RDdata_o=wb_data_i. The FIFO head is not written this cycle; if the head is killed, it is still popped.
  2. Else if the FIFO is non-empty and the head is live: next RegWrite_o=1 with the head's addr/data; pop the head.
  3. Else: next RegWrite_o=0; RDaddr_o/RDdata_o hold their values. A killed head is popped silently.
  - At most one pop per cycle.
  - A wb_we_i write to address 0 is dropped: no write, and no kill is applied.
- Latency: a WB write appears on the RegWrite_o port 1 cycle later. An LU write appears no earlier than 1 cycle after accept when the FIFO is empty and WB is idle.
- Kill rule: WB is always program-order newer than every LU write accepted in the same or an earlier cycle.
  - A WB write to X (X!=0) clears live on every queued entry with addr==X.
  - The same WB write also clears live on an LU write to X accepted in the same cycle.
  - A killed entry never reaches the write port.
- Pending flags:
  - rs_pending_o=1 iff rs_addr_i!=0 and some live queued entry has addr==rs_addr_i.
  - rt_pending_o follows the same rule using rt_addr_i.
  - Both are combinational from stored state plus the read address; they ignore same-cycle accepts and kills.
- LU ordering: LU writes retire in acceptance order. Two queued writes to the same address both retire; the later one wins in the register file.

Test Plan:
- Reset, then a single LU write: lu_valid_i=1, addr=7, data=0x1234 → lu_ready_o=1; next cycle RegWrite_o=1, RDaddr_o=7, RDdata_o=0x1234; count_o returns to 0.
- WB priority: wb_we_i held for 3 cycles (addr 3,4,5) while the LU enqueues addr 9 → three WB writes appear in order; the addr-9 write appears on the 4th cycle after; count_o reaches 1 then 0.
- Full FIFO: hold wb_we_i=1 (addr 1) and push 5 LU writes (addr 10..14) → lu_ready_o drops after 4 accepts; count_o=4; rs_addr_i=12 gives rs_pending_o=1; after WB releases, 10..13 retire on consecutive cycles.
- Kill: queue an LU write to r8 (data 0xAAAA) while WB is busy, then WB writes r8=0x5555 → only 0x5555 reaches r8; rs_pending_o for r8 goes to 0 the cycle after the kill.
- Register 0: an LU write and a WB write to addr 0 → RegWrite_o stays 0; pending flags stay 0; the LU entry is popped silently.
- Asynchronous reset mid-operation: 3 entries queued, assert rst_i between edges → outputs go to 0 immediately; after release count_o=0 and no queued write appears.
